// File: rtl/ram_ctrl.sv
// ram_ctrl: burst read/write initiator for a 32x256 single-port RAM on a shared data bus.
// The read path is pipelined: address issue, then RAM output register, then bus capture, then rd_valid.

module ram_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          en_write,
  output logic          en_read,
  output logic [AW-1:0] addr_ram_out,
  inout  logic [DW-1:0] data_ram_io
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_RDRAIN = 3'd3;
  localparam logic [2:0] S_TURN   = 3'd4;

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_cnt;
  logic          r_p1;
  logic          r_p1_last;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [DW-1:0] r_rd_data;

  logic          w_last;
  logic          w_en_write;
  logic          w_en_read;

  assign w_last     = (r_cnt == '0);
  assign w_en_write = (r_state == S_WRITE) && wr_valid;
  assign w_en_read  = (r_state == S_READ) || (r_state == S_RDRAIN);

  assign cmd_ready    = (r_state == S_IDLE);
  assign wr_ready     = (r_state == S_WRITE);
  assign busy         = (r_state != S_IDLE);
  assign en_write     = w_en_write;
  assign en_read      = w_en_read;
  assign addr_ram_out = r_addr;
  assign rd_valid     = r_rd_valid;
  assign rd_last      = r_rd_last;
  assign rd_data      = r_rd_data;

  // The controller only ever drives the bus while a write beat is in flight.
  assign data_ram_io = w_en_write ? wr_data : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_p1       <= 1'b0;
      r_p1_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      // r_p1 marks a cycle whose bus content belongs to an issued read address.
      r_p1       <= 1'b0;
      r_p1_last  <= 1'b0;
      r_rd_valid <= r_p1;
      r_rd_last  <= r_p1 & r_p1_last;
      if (r_p1) begin
        r_rd_data <= data_ram_io;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_cnt   <= cmd_len;
            r_state <= cmd_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - LW'(1);
            if (w_last) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_READ: begin
          r_p1      <= 1'b1;
          r_p1_last <= w_last;
          if (w_last) begin
            r_state <= S_RDRAIN;
          end else begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - LW'(1);
          end
        end
        S_RDRAIN: r_state <= S_TURN;
        S_TURN:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural 32x256 single-port RAM on the shared bus.
// The RAM registers mem[addr] while en_read is high and drives that word while en_read is high.

module tb_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        en_write;
  logic        en_read;
  logic [7:0]  addr_ram_out;
  wire  [31:0] data_ram_io;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int viol     = 0;

  logic [31:0] mem [256];
  logic [31:0] ram_q;
  logic [31:0] wd [16];
  logic [31:0] ed [16];

  logic [31:0] q_data [$];
  logic        q_last [$];
  int          q_cyc  [$];

  ram_ctrl #(.DW(32), .AW(8), .LW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .en_write(en_write), .en_read(en_read), .addr_ram_out(addr_ram_out),
    .data_ram_io(data_ram_io)
  );

  initial begin
    ram_q = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (en_write) mem[addr_ram_out] <= data_ram_io;
    if (en_read)  ram_q <= mem[addr_ram_out];
  end
  assign data_ram_io = en_read ? ram_q : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rd_valid) begin
      q_data.push_back(rd_data);
      q_last.push_back(rd_last);
      q_cyc.push_back(cyc);
    end
    if (en_read && en_write) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] len, input int gap);
    logic [7:0] ea;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ea = a + i[7:0];
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          #1;
          chk("wr_gap_en", en_write, 1'b0);
          chk("wr_gap_addr", addr_ram_out, ea);
          chk("wr_gap_busy", busy, 1'b1);
          tick();
        end
      end
      wr_valid = 1'b1; wr_data = wd[i];
      #1;
      chk("wr_en", en_write, 1'b1);
      chk("wr_addr", addr_ram_out, ea);
      chk("wr_bus", data_ram_io, wd[i]);
      chk("wr_ready", wr_ready, 1'b1);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_done_busy", busy, 1'b0);
    chk("wr_done_en", en_write, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len, input bit mid);
    int k;
    logic [7:0] ea;
    q_data.delete(); q_last.delete(); q_cyc.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
    k = cyc;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (mid && i == 4) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; end
      if (mid && i == 8) cmd_valid = 1'b0;
      #1;
      ea = a + i[7:0];
      chk("rd_addr", addr_ram_out, ea);
      chk("rd_en", en_read, 1'b1);
      chk("rd_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    ea = a + {4'h0, len};
    chk("drain_en", en_read, 1'b1);
    chk("drain_addr", addr_ram_out, ea);
    tick();
    chk("turn_en_read", en_read, 1'b0);
    chk("turn_en_write", en_write, 1'b0);
    chk("turn_busy", busy, 1'b1);
    tick();
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_idle_ready", cmd_ready, 1'b1);
    chk("rd_beats", q_data.size(), int'(len) + 1);
    for (int i = 0; i < q_data.size() && i <= int'(len); i++) begin
      chk("rd_data", q_data[i], ed[i]);
      chk("rd_last", q_last[i], (i == int'(len)));
      chk("rd_cycle", q_cyc[i], k + 3 + i);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (2) tick();
    chk("rst_en_write", en_write, 1'b0);
    chk("rst_en_read", en_read, 1'b0);
    chk("rst_addr", addr_ram_out, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    tick();

    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    #1;
    chk("idle_no_write", en_write, 1'b0);
    wr_valid = 1'b0;
    tick();

    wd[0] = 32'hDEAD_BEEF;
    do_write(8'h10, 4'd0, 0);
    ed[0] = 32'hDEAD_BEEF;
    do_read(8'h10, 4'd0, 1'b0);

    for (int i = 0; i < 4; i++) wd[i] = i + 1;
    do_write(8'hFE, 4'd3, 0);
    chk("mem_FE", mem[8'hFE], 32'd1);
    chk("mem_FF", mem[8'hFF], 32'd2);
    chk("mem_00", mem[8'h00], 32'd3);
    chk("mem_01", mem[8'h01], 32'd4);
    for (int i = 0; i < 4; i++) ed[i] = i + 1;
    do_read(8'hFE, 4'd3, 1'b0);

    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    do_write(8'h20, 4'd2, 2);
    chk("mem_20", mem[8'h20], 32'hA0);
    chk("mem_21", mem[8'h21], 32'hA1);
    chk("mem_22", mem[8'h22], 32'hA2);
    ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hA2;
    do_read(8'h20, 4'd2, 1'b0);

    ed[0] = 32'hA1;
    do_read(8'h21, 4'd0, 1'b0);
    wd[0] = 32'h5555_AAAA;
    do_write(8'h31, 4'd0, 0);
    ed[0] = 32'h5555_AAAA;
    do_read(8'h31, 4'd0, 1'b0);

    for (int i = 0; i < 16; i++) wd[i] = 32'hF00 + i;
    do_write(8'hF8, 4'd15, 0);
    for (int i = 0; i < 16; i++) ed[i] = 32'hF00 + i;
    do_read(8'hF8, 4'd15, 1'b1);
    tick();
    chk("mid_cmd_ignored", busy, 1'b0);

    for (int i = 0; i < 16; i++) wd[i] = 32'h100 + i;
    do_write(8'h40, 4'd15, 0);
    q_data.delete(); q_last.delete(); q_cyc.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; cmd_len = 4'd15;
    tick();
    cmd_valid = 1'b0;
    guard = 0;
    while (q_data.size() < 5 && guard < 20) begin
      tick();
      guard++;
    end
    chk("pre_rst_beats", q_data.size(), 5);
    if (q_data.size() >= 5) chk("pre_rst_beat4", q_data[4], 32'h104);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en_read", en_read, 1'b0);
    chk("mid_rst_en_write", en_write, 1'b0);
    chk("mid_rst_addr", addr_ram_out, 8'h00);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_rd_last", rd_last, 1'b0);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_no_beats", q_data.size(), 5);
    chk("post_rst_busy", busy, 1'b0);
    ed[0] = 32'h105; ed[1] = 32'h106; ed[2] = 32'h107;
    do_read(8'h45, 4'd2, 1'b0);

    chk("bus_overlap", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator and controller for the 32x256 single-port RAM with the shared bidirectional data bus.
- Accepts burst read/write commands from a client over valid/ready handshakes.
- Sequences en_write, en_read, address and bus direction on the RAM side, including read-to-idle bus turnaround.
- Sits between the datapath client and the RAM; the only agent that drives the RAM control pins.

Parameters:
DW, 32, data width (matches RAM word)
AW, 8, address width (matches RAM depth 256)
LW, 4, burst length field width; burst beats = cmd_len+1 (1..16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  controller accepts command (high only in IDLE)
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  AW  burst start address
cmd_len  input  LW  beats minus one
wr_valid  input  1  write data beat available
wr_ready  output  1  write beat accepted this cycle
wr_data  input  DW  write data
rd_valid  output  1  read beat valid (single-cycle pulse per beat, no backpressure)
rd_data  output  DW  read data
rd_last  output  1  final beat of read burst, qualified by rd_valid
busy  output  1  state != IDLE
en_write  output  1  RAM write enable
en_read  output  1  RAM read enable / RAM bus-drive enable
addr_ram_out  output  AW  RAM address
data_ram_io  inout  DW  shared RAM data bus

Behaviour:
- Reset (async, rst_n low): state=IDLE; en_write=0, en_read=0, addr_ram_out=0, rd_valid=0, rd_last=0, rd_data=0, busy=0; data_ram_io released (Z). cmd_ready=1 once reset is released. Reset mid-burst aborts the burst; no further rd_valid pulses; the partial write burst stays in RAM.
- Bus ownership: data_ram_io driven with wr_data only when en_write=1; Z otherwise. en_write and en_read are never high in the same cycle.
- States: IDLE, WRITE, READ, RDRAIN, TURN.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/dir at the clock edge. Go to WRITE if cmd_write=1, else READ.
- WRITE: wr_ready=1. en_write = wr_valid (combinational). addr_ram_out = current address.
  - Each cycle with wr_valid=1 is one beat: RAM captures at that edge, address increments, beat count decrements.
  - wr_valid low inserts a bubble: no write, address held.
  - After the last beat, go to IDLE.
- READ: en_read=1 every cycle; addr_ram_out issues one address per cycle. No stalls.
  - After the last address is issued, go to RDRAIN.
- RDRAIN: en_read=1, address held at the last value, one cycle; samples the final beat. Then go to TURN.
- TURN: en_read=0, en_write=0, one cycle, lets the RAM release the bus. Then go to IDLE.
- Read timing:
  - Address An is issued in cycle c.
  - RAM registers mem[An] at the end of cycle c and drives the bus in cycle c+1.
  - The controller registers the bus into rd_data at the end of c+1; rd_valid=1 in cycle c+2.
- Accept-to-first-rd_valid latency = 3 cycles. Beats are back-to-back. rd_last accompanies beat len.
- Address arithmetic: AW-bit increment, wraps 0xFF->0x00. Length counter is LW bits; cmd_len=0 gives a single beat.
- Commands are accepted only in IDLE; cmd_valid during a burst is ignored and held off by cmd_ready=0.
- Write-after-read is always separated by at least TURN. Read-after-write needs no gap.

Test Plan:
- Single write then single read: write 0xDEADBEEF @0x10, then read @0x10. Required: rd_valid exactly 3 cycles after read accept, rd_data=0xDEADBEEF, rd_last=1.
- Wrapping burst write: addr=0xFE, len=3, data 1,2,3,4. Then read 4 @0xFE. Required: RAM addresses 0xFE,0xFF,0x00,0x01 hold 1..4; rd_data sequence 1,2,3,4 on consecutive cycles; rd_last only on the 4th beat.
- Write backpressure: len=2 with wr_valid low for 2 cycles between beats. Required: en_write low and address held during gaps; 3 words written to consecutive addresses; busy stays high until the last beat.
- Read-then-write turnaround: read len=0 immediately followed by a write command. Required: one TURN cycle with en_read=en_write=0; controller never drives the bus while en_read=1 (no X on data_ram_io).
- Max burst: read len=15 @0xF8. Required: 16 contiguous rd_valid pulses, addresses wrap after 0xFF; cmd_ready low throughout; cmd_valid asserted mid-burst is not accepted.
- Reset mid-read-burst: assert rst_n=0 after 5 beats. Required: outputs immediately return to reset values; data_ram_io=Z; no rd_valid after release; next command completes normally.
